// File: rtl/writeback_stage.sv
// MIPS WB stage: MEM/WB register, load extraction/extension and register-file write port.
// Optional retired-instruction counter is built when WB_RETIRE_CNT_EN is defined.
module writeback_stage #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 5,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst,
  input  logic                 wb_i_ce,
  input  logic                 wb_i_stall,
  input  logic                 wb_i_flush,
  input  logic                 wb_i_reg_wr,
  input  logic                 wb_i_mem_to_reg,
  input  logic [2:0]           wb_i_load_type,
  input  logic [AWIDTH-1:0]    wb_i_addr_rd,
  input  logic [DWIDTH-1:0]    wb_i_alu_value,
  input  logic [DWIDTH-1:0]    wb_i_load_data,
`ifdef WB_RETIRE_CNT_EN
  output logic [CNT_WIDTH-1:0] wb_o_retired,
`endif
  output logic                 wb_o_ce,
  output logic                 wb_o_reg_wr,
  output logic [AWIDTH-1:0]    wb_o_addr_rd,
  output logic [DWIDTH-1:0]    wb_o_data_rd,
  output logic                 wb_o_misalign
);

  localparam logic [2:0] LT_LW  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LHU = 3'b010;
  localparam logic [2:0] LT_LB  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;

  logic              ce_q;
  logic              reg_wr_q;
  logic              m2r_q;
  logic [2:0]        lt_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] alu_q;
  logic [DWIDTH-1:0] ld_q;

  // Undefined load types behave as LW, so they need full word alignment.
  function automatic logic is_misaligned(input logic m2r, input logic [2:0] lt,
                                         input logic [1:0] off);
    logic bad;
    case (lt)
      LT_LH, LT_LHU: bad = off[0];
      LT_LB, LT_LBU: bad = 1'b0;
      default:       bad = (off != 2'b00);
    endcase
    return m2r & bad;
  endfunction

  always_ff @(posedge wb_clk) begin
    if (wb_rst || wb_i_flush) begin
      ce_q     <= 1'b0;
      reg_wr_q <= 1'b0;
      m2r_q    <= 1'b0;
      lt_q     <= 3'b000;
      addr_q   <= '0;
      alu_q    <= '0;
      ld_q     <= '0;
    end else if (!wb_i_stall) begin
      ce_q     <= wb_i_ce;
      reg_wr_q <= wb_i_reg_wr;
      m2r_q    <= wb_i_mem_to_reg;
      lt_q     <= wb_i_load_type;
      addr_q   <= wb_i_addr_rd;
      alu_q    <= wb_i_alu_value;
      ld_q     <= wb_i_load_data;
    end
  end

  logic [1:0]        off;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DWIDTH-1:0] extracted;

  assign off = alu_q[1:0];

  always_comb begin
    byte_sel  = ld_q[{off, 3'b000} +: 8];
    half_sel  = off[1] ? ld_q[31:16] : ld_q[15:0];
    extracted = ld_q;
    case (lt_q)
      LT_LH:   extracted = {{(DWIDTH-16){half_sel[15]}}, half_sel};
      LT_LHU:  extracted = {{(DWIDTH-16){1'b0}}, half_sel};
      LT_LB:   extracted = {{(DWIDTH-8){byte_sel[7]}}, byte_sel};
      LT_LBU:  extracted = {{(DWIDTH-8){1'b0}}, byte_sel};
      default: extracted = ld_q;
    endcase
  end

  assign wb_o_ce       = ce_q;
  assign wb_o_addr_rd  = addr_q;
  assign wb_o_data_rd  = m2r_q ? extracted : alu_q;
  assign wb_o_misalign = ce_q & is_misaligned(m2r_q, lt_q, off);
  assign wb_o_reg_wr   = ce_q & reg_wr_q & (addr_q != '0) & ~wb_o_misalign;

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_WIDTH-1:0] retired_q;

  // Count at capture time, so stalled repeats and discarded holds never count.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      retired_q <= '0;
    end else if (!wb_i_flush && !wb_i_stall && wb_i_ce &&
                 !is_misaligned(wb_i_mem_to_reg, wb_i_load_type, wb_i_alu_value[1:0])) begin
      retired_q <= retired_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign wb_o_retired = retired_q;
`endif

endmodule
